// File: rtl/conv_pkg.sv
// Shared definitions for the convolution accelerator input side:
// default geometry, derived address widths and the loader state type.
package conv_pkg;

  localparam int INW_DEF  = 12;
  localparam int R_DEF    = 16;
  localparam int C_DEF    = 17;
  localparam int MAXK_DEF = 4;

  localparam int X_ADDR_BITS = $clog2(R_DEF * C_DEF);
  localparam int W_ADDR_BITS = $clog2(MAXK_DEF * MAXK_DEF);
  localparam int K_BITS      = $clog2(MAXK_DEF + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    LOAD_X = 2'd2,
    DONE   = 2'd3
  } load_state_t;

endpackage

// File: rtl/memory_dual_port.sv
// Simple dual-port RAM: one synchronous write port, one read port with a
// single cycle of registered read latency. Contents are never reset.
module memory_dual_port #(
  parameter int WIDTH     = 12,
  parameter int SIZE      = 16,
  parameter int ADDR_BITS = $clog2(SIZE)
) (
  input  logic                 clk,
  input  logic                 write_enable,
  input  logic [ADDR_BITS-1:0] write_addr,
  input  logic [WIDTH-1:0]     write_data,
  input  logic [ADDR_BITS-1:0] read_addr,
  output logic [WIDTH-1:0]     read_data
);

  logic [WIDTH-1:0] mem [SIZE];

  // Write on the clock edge when enabled; read data is registered.
  always_ff @(posedge clk) begin
    if (write_enable) begin
      mem[write_addr] <= write_data;
    end
    read_data <= mem[read_addr];
  end

endmodule

// File: rtl/input_mems_loader.sv
// AXI-Stream sink that fills the kernel (W) and image (X) operand memories
// for the convolution core, then holds them until the core releases them.
module input_mems_loader
  import conv_pkg::*;
#(
  parameter  int INW         = INW_DEF,
  parameter  int R           = R_DEF,
  parameter  int C           = C_DEF,
  parameter  int MAXK        = MAXK_DEF,
  localparam int X_ADDR_BITS = $clog2(R * C),
  localparam int W_ADDR_BITS = $clog2(MAXK * MAXK),
  localparam int K_BITS      = $clog2(MAXK + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INW-1:0]         INPUT_TDATA,
  input  logic                   INPUT_TVALID,
  input  logic [K_BITS:0]        INPUT_TUSER,
  output logic                   INPUT_TREADY,
  output logic                   inputs_loaded,
  input  logic                   compute_finished,
  output logic [K_BITS-1:0]      K,
  input  logic [X_ADDR_BITS-1:0] X_read_addr,
  output logic [INW-1:0]         X_data,
  input  logic [W_ADDR_BITS-1:0] W_read_addr,
  output logic [INW-1:0]         W_data
);

  localparam logic [X_ADDR_BITS-1:0] X_LAST = X_ADDR_BITS'(R * C - 1);

  // A kernel size of 0 or above MAXK is treated as the largest kernel.
  function automatic logic [K_BITS-1:0] sat_k(input logic [K_BITS-1:0] k_in);
    if (k_in == '0 || k_in > K_BITS'(MAXK)) begin
      return K_BITS'(MAXK);
    end
    return k_in;
  endfunction

  // Index of the last kernel element for a KxK kernel.
  function automatic logic [W_ADDR_BITS-1:0] w_last_idx(input logic [K_BITS-1:0] k_in);
    int sq;
    sq = int'(k_in) * int'(k_in) - 1;
    return W_ADDR_BITS'(sq);
  endfunction

  load_state_t             state, state_n;
  logic [X_ADDR_BITS-1:0]  xcnt, xcnt_n;
  logic [W_ADDR_BITS-1:0]  wcnt, wcnt_n;
  logic [K_BITS-1:0]       k_reg, k_n;
  logic                    accept;
  logic                    x_we, w_we;
  logic [X_ADDR_BITS-1:0]  x_waddr;
  logic [W_ADDR_BITS-1:0]  w_waddr;
  logic [K_BITS-1:0]       k_field;

  assign INPUT_TREADY  = (state != DONE);
  assign inputs_loaded = (state == DONE);
  assign K             = k_reg;
  assign accept        = INPUT_TVALID && INPUT_TREADY;
  assign k_field       = INPUT_TUSER[K_BITS:1];

  // Control registers: state, write counters and the latched kernel size.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      xcnt  <= '0;
      wcnt  <= '0;
      k_reg <= '0;
    end else begin
      state <= state_n;
      xcnt  <= xcnt_n;
      wcnt  <= wcnt_n;
      k_reg <= k_n;
    end
  end

  // Next-state, counter and memory-write decode for each accepted beat.
  always_comb begin
    state_n = state;
    xcnt_n  = xcnt;
    wcnt_n  = wcnt;
    k_n     = k_reg;
    x_we    = 1'b0;
    w_we    = 1'b0;
    x_waddr = xcnt;
    w_waddr = wcnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (INPUT_TUSER[0]) begin
            k_n     = sat_k(k_field);
            w_we    = 1'b1;
            w_waddr = '0;
            if (sat_k(k_field) == K_BITS'(1)) begin
              xcnt_n  = '0;
              state_n = LOAD_X;
            end else begin
              wcnt_n  = W_ADDR_BITS'(1);
              state_n = LOAD_W;
            end
          end else begin
            x_we    = 1'b1;
            x_waddr = '0;
            xcnt_n  = X_ADDR_BITS'(1);
            state_n = LOAD_X;
          end
        end
      end
      LOAD_W: begin
        if (accept) begin
          w_we = 1'b1;
          if (wcnt == w_last_idx(k_reg)) begin
            wcnt_n  = '0;
            xcnt_n  = '0;
            state_n = LOAD_X;
          end else begin
            wcnt_n = wcnt + 1'b1;
          end
        end
      end
      LOAD_X: begin
        if (accept) begin
          x_we = 1'b1;
          if (xcnt == X_LAST) begin
            state_n = DONE;
          end else begin
            xcnt_n = xcnt + 1'b1;
          end
        end
      end
      DONE: begin
        if (compute_finished) begin
          xcnt_n  = '0;
          wcnt_n  = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  memory_dual_port #(
    .WIDTH     (INW),
    .SIZE      (R * C),
    .ADDR_BITS (X_ADDR_BITS)
  ) u_x_mem (
    .clk          (clk),
    .write_enable (x_we),
    .write_addr   (x_waddr),
    .write_data   (INPUT_TDATA),
    .read_addr    (X_read_addr),
    .read_data    (X_data)
  );

  memory_dual_port #(
    .WIDTH     (INW),
    .SIZE      (MAXK * MAXK),
    .ADDR_BITS (W_ADDR_BITS)
  ) u_w_mem (
    .clk          (clk),
    .write_enable (w_we),
    .write_addr   (w_waddr),
    .write_data   (INPUT_TDATA),
    .read_addr    (W_read_addr),
    .read_data    (W_data)
  );

endmodule

// File: tb/tb_input_mems_loader.sv
// Randomized scoreboard bench for input_mems_loader: a transfer-level
// reference model tracks W, X and K; reads push expectations into a queue
// that a separate monitor pops and compares one cycle later.
module tb_input_mems_loader;

  localparam int INW = 12;
  localparam int R   = 16;
  localparam int C   = 17;
  localparam int XN  = R * C;
  localparam int MAXK = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] tdata;
  logic        tvalid;
  logic [3:0]  tuser;
  logic        tready;
  logic        loaded;
  logic        cf;
  logic [2:0]  kout;
  logic [8:0]  xra;
  logic [11:0] xd;
  logic [3:0]  wra;
  logic [11:0] wd;

  input_mems_loader #(.INW(INW), .R(R), .C(C), .MAXK(MAXK)) dut (
    .clk              (clk),
    .reset            (reset),
    .INPUT_TDATA      (tdata),
    .INPUT_TVALID     (tvalid),
    .INPUT_TUSER      (tuser),
    .INPUT_TREADY     (tready),
    .inputs_loaded    (loaded),
    .compute_finished (cf),
    .K                (kout),
    .X_read_addr      (xra),
    .X_data           (xd),
    .W_read_addr      (wra),
    .W_data           (wd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  int ref_w [16];
  int ref_x [XN];
  int ref_k;

  // Stimulus buffers for the next transfer.
  int stim_w [16];
  int stim_x [XN];

  typedef struct {
    bit  is_x;
    int  addr;
    int  exp;
    longint due;
  } rd_t;
  rd_t rq[$];
  longint cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: compares each read one cycle after its address was presented.
  always @(negedge clk) begin
    while (rq.size() > 0 && rq[0].due <= cyc) begin
      rd_t r;
      r = rq.pop_front();
      if (r.is_x) chk($sformatf("X_data[%0d]", r.addr), int'(xd), r.exp);
      else        chk($sformatf("W_data[%0d]", r.addr), int'(wd), r.exp);
    end
  end

  function automatic int sat_model(input int k);
    return (k == 0 || k > MAXK) ? MAXK : k;
  endfunction

  // Present one read address (called at a negedge) and queue the expectation.
  task automatic rd(input bit is_x, input int addr);
    rd_t r;
    if (is_x) xra = 9'(addr); else wra = 4'(addr);
    r.is_x = is_x;
    r.addr = addr;
    r.exp  = is_x ? (ref_x[addr] & 12'hFFF) : (ref_w[addr] & 12'hFFF);
    r.due  = cyc + 1;
    rq.push_back(r);
    @(negedge clk);
  endtask

  task automatic verify_all();
    chk("K", int'(kout), ref_k);
    for (int i = 0; i < ref_k * ref_k; i++) rd(1'b0, i);
    for (int n = 0; n < XN; n++) rd(1'b1, n);
    for (int g = 0; g < 4 && rq.size() > 0; g++) @(negedge clk);
    chk("read_queue_drained", rq.size(), 0);
  endtask

  // Drive one transfer; stops after abort_after accepted beats if smaller.
  task automatic load(input bit new_w, input int kfield, input int duty,
                      input int abort_after, input bit poke_cf);
    int kk, nw, total, idx, guard, first, last, wa;
    bit early, rdy, v;
    kk    = new_w ? sat_model(kfield) : ref_k;
    nw    = new_w ? kk * kk : 0;
    total = nw + XN;
    idx = 0; guard = 0; first = -1; last = -1; early = 0;
    while (idx < total && idx < abort_after && guard < 20000) begin
      v      = ($urandom_range(99) < duty);
      tvalid = v;
      tdata  = 12'(idx < nw ? stim_w[idx] : stim_x[idx - nw]);
      tuser  = (idx == 0) ? {3'(kfield), new_w} : 4'($urandom);
      cf     = poke_cf && ($urandom_range(15) == 0);
      rdy    = tready;
      @(posedge clk);
      if (v && rdy) begin
        if (idx == 0) first = guard;
        last = guard;
        idx++;
      end
      guard++;
      @(negedge clk);
      if (loaded && idx < total) early = 1'b1;
    end
    tvalid = 1'b0;
    cf     = 1'b0;
    chk("load_no_timeout", int'(guard < 20000), 1);
    wa = (idx < nw) ? idx : nw;
    for (int i = 0; i < wa; i++) ref_w[i] = stim_w[i];
    for (int n = 0; n < idx - wa; n++) ref_x[n] = stim_x[n];
    if (new_w && idx > 0) ref_k = kk;
    chk("loaded_early", int'(early), 0);
    if (idx == total) begin
      chk("inputs_loaded", int'(loaded), 1);
      chk("tready_done", int'(tready), 0);
      if (duty >= 100) chk("load_cycles", last - first + 1, total);
    end else begin
      chk("inputs_loaded_partial", int'(loaded), 0);
    end
  endtask

  task automatic release_core();
    cf = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cf = 1'b0;
    chk("release_tready", int'(tready), 1);
    chk("release_loaded", int'(loaded), 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) stim_w[i] = int'($urandom_range(4095));
    for (int n = 0; n < XN; n++) stim_x[n] = int'($urandom_range(4095));
  endtask

  initial begin
    bit bad;
    reset = 1'b1; tvalid = 1'b0; tdata = '0; tuser = '0; cf = 1'b0;
    xra = '0; wra = '0; ref_k = 0;
    for (int i = 0; i < 16; i++) ref_w[i] = 0;
    for (int n = 0; n < XN; n++) ref_x[n] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_tready", int'(tready), 1);
    chk("reset_loaded", int'(loaded), 0);
    chk("reset_K", int'(kout), 0);

    // Test 1: K=3 kernel W[i]=i+1, X[n]=n-100, no bubbles.
    for (int i = 0; i < 16; i++) stim_w[i] = i + 1;
    for (int n = 0; n < XN; n++) stim_x[n] = n - 100;
    load(1'b1, 3, 100, 1 << 20, 1'b0);
    verify_all();

    // Test 2: valid held in DONE must be refused and memory untouched.
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tvalid = 1'b1;
      tdata  = 12'($urandom);
      tuser  = 4'($urandom);
      @(posedge clk);
      @(negedge clk);
      if (tready !== 1'b0 || loaded !== 1'b1) bad = 1'b1;
    end
    tvalid = 1'b0;
    chk("done_holds_off", int'(bad), 0);
    verify_all();
    release_core();

    // Test 3: new_W=0 keeps W and K, X[n]=2n.
    for (int n = 0; n < XN; n++) stim_x[n] = 2 * n;
    load(1'b0, 0, 100, 1 << 20, 1'b0);
    verify_all();
    release_core();

    // Test 4: K=2 with random gaps and stray compute_finished pulses.
    fill_random();
    load(1'b1, 2, 50, 1 << 20, 1'b1);
    verify_all();
    release_core();

    // Test 5: out-of-range kernel sizes saturate to MAXK.
    fill_random();
    load(1'b1, 0, 80, 1 << 20, 1'b0);
    verify_all();
    release_core();
    fill_random();
    load(1'b1, 7, 100, 1 << 20, 1'b0);
    verify_all();
    release_core();

    // Test 6: reset after 100 X beats, then a fresh K=1 load.
    fill_random();
    load(1'b1, 2, 100, 4 + 100, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    ref_k = 0;
    chk("midreset_tready", int'(tready), 1);
    chk("midreset_loaded", int'(loaded), 0);
    chk("midreset_K", int'(kout), 0);
    fill_random();
    load(1'b1, 1, 100, 1 << 20, 1'b0);
    verify_all();
    release_core();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/input_mems_loader.md
Name: input_mems_loader

Overview:
- Input-side AXI-Stream sink for the 2D convolution accelerator. It is the writer that fills the operand memories the compute core reads, mirroring the result FIFO at the output end.
- Accepts a beat stream carrying an optional KxK kernel W followed by an RxC input matrix X, and stores both in on-chip memories.
- Asserts inputs_loaded and holds the data stable until the core pulses compute_finished, then accepts the next image.

Parameters:
- INW, 12: data width of X and W elements (signed, two's complement).
- R, 16: rows of X.
- C, 17: columns of X.
- MAXK, 4: maximum kernel dimension.
- Derived, not overridable:
  - X_ADDR_BITS = $clog2(R*C)
  - W_ADDR_BITS = $clog2(MAXK*MAXK)
  - K_BITS = $clog2(MAXK+1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- INPUT_TDATA  in  INW  stream element
- INPUT_TVALID  in  1  upstream beat valid
- INPUT_TUSER  in  K_BITS+1  bit0 = new_W; [K_BITS:1] = K; sampled only on the first beat of a transfer
- INPUT_TREADY  out  1  loader accepts a beat
- inputs_loaded  out  1  W and X are complete and stable
- compute_finished  in  1  single-cycle pulse from the core releasing the memories
- K  out  K_BITS  current kernel size
- X_read_addr  in  X_ADDR_BITS  core read address, row-major r*C+c
- X_data  out  INW  X element, 1-cycle read latency
- W_read_addr  in  W_ADDR_BITS  core read address, row-major i*K+j
- W_data  out  INW  W element, 1-cycle read latency

Behaviour:
- Handshake: a beat is accepted when INPUT_TVALID && INPUT_TREADY at posedge clk. The accepted beat is written to memory on that edge.
- INPUT_TREADY is combinational from state: 1 in IDLE, LOAD_W and LOAD_X; 0 in DONE.
- State IDLE, first beat accepted:
  - TUSER[0]=1: latch K from TUSER[K_BITS:1]. If that field is 0 or greater than MAXK, saturate to MAXK. Write the beat to W[0].
    - If K==1, go to LOAD_X with the X counter at 0.
    - Otherwise set the W counter to 1 and go to LOAD_W.
  - TUSER[0]=0: keep the previous W and K. Write the beat to X[0], set the X counter to 1, go to LOAD_X.
- LOAD_W: each accepted beat writes W[wcnt] and increments wcnt.
  - The beat at wcnt == K*K-1 moves to LOAD_X with the X counter at 0.
  - TUSER is ignored.
- LOAD_X: each accepted beat writes X[xcnt] and increments xcnt.
  - The beat at xcnt == R*C-1 moves to DONE.
  - Counters do not wrap beyond R*C-1; they return to 0 on leaving DONE.
- DONE: inputs_loaded=1 and INPUT_TREADY=0. Memories are never written.
  - compute_finished=1 returns to IDLE on the next edge.
  - compute_finished in any other state is ignored.
- inputs_loaded is registered state decode. It rises the cycle after the last X beat is accepted.
- K is a register and changes only on a new_W first beat.
- Read ports:
  - X_data and W_data reflect the address presented one cycle earlier, in any state.
  - The contents are guaranteed only while inputs_loaded=1.
- Minimum load time: K*K + R*C cycles with TVALID held high (no bubbles inserted by the loader).
- Upstream may deassert TVALID at any point; the counters hold.
- Reset, including mid-load:
  - State goes to IDLE, counters to 0, K to 0, inputs_loaded to 0, INPUT_TREADY to 1.
  - Memory contents are not cleared.
  - The next transfer after reset must carry new_W=1. If it does not, K=0 and W are undefined; the core's behaviour is not this block's concern.

Decomposition:
- Package conv_pkg holds:
  - Default INW/R/C/MAXK
  - X_ADDR_BITS, W_ADDR_BITS, K_BITS as localparams of MAXK/R/C
  - typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_X, DONE} load_state_t
- Sub-modules: two instances of the team's memory_dual_port.
  - Write port driven by the loader counters; read port driven by X_read_addr / W_read_addr.
  - SIZE R*C and MAXK*MAXK respectively.
- No new sub-module.

Test Plan:
1. Reset, then new_W=1 with K=3: 9 W beats, W[i]=i+1, then 272 X beats, X[n]=n-100, TVALID held high. Expected: inputs_loaded rises 281 cycles after the first acceptance; W_read_addr=4 gives W_data=5 next cycle; X_read_addr=271 gives X_data=171.
2. In DONE, hold TVALID=1 for 20 cycles. Expected: TREADY=0 throughout and memory unchanged. Pulse compute_finished. Expected: IDLE next cycle, TREADY=1, inputs_loaded=0.
3. Second image with new_W=0, X[n]=2n. Expected: K stays 3, W still reads 1..9, inputs_loaded after exactly 272 accepted beats.
4. Random TVALID gaps (~50% duty) during a K=2 load. Expected: all 4+272 values land at the correct addresses; inputs_loaded only after the 276th acceptance.
5. new_W=1 with TUSER K=0, and separately K=7. Expected: K saturates to 4 in both cases and 16 W beats are expected.
6. Assert reset after 100 X beats. Expected: next cycle state IDLE, inputs_loaded=0, TREADY=1, K=0. A fresh K=1 load then completes after 1+272 beats.
